// File: rtl/game_pkg.sv
// Shared game definitions: state encoding and BCD digit width, also used by the display mux.
package game_pkg;

    localparam int STATE_W     = 3;
    localparam int BCD_DIGIT_W = 4;

    localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] ST_COUNTDOWN = 3'd1;
    localparam logic [STATE_W-1:0] ST_PLAY      = 3'd2;
    localparam logic [STATE_W-1:0] ST_GAMEOVER  = 3'd3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE      = ST_IDLE,
        S_COUNTDOWN = ST_COUNTDOWN,
        S_PLAY      = ST_PLAY,
        S_GAMEOVER  = ST_GAMEOVER
    } state_e;

    // Binary 0..99 to two packed BCD digits.
    function automatic logic [2*BCD_DIGIT_W-1:0] to_bcd2(input int unsigned v);
        return {BCD_DIGIT_W'(v / 10), BCD_DIGIT_W'(v % 10)};
    endfunction

endpackage

// File: rtl/game_sequencer_bcd2_counter.sv
// Two-digit BCD counter: load has priority, then inc (saturates at 99), then dec (stops at 00).
module bcd2_counter
    import game_pkg::*;
#(
    parameter logic [2*BCD_DIGIT_W-1:0] RST_VAL = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     load_i,
    input  logic [2*BCD_DIGIT_W-1:0] load_val_i,
    input  logic                     inc_i,
    input  logic                     dec_i,
    output logic [2*BCD_DIGIT_W-1:0] value_o
);

    logic [BCD_DIGIT_W-1:0] tens_q, tens_d;
    logic [BCD_DIGIT_W-1:0] ones_q, ones_d;

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (load_i) begin
            {tens_d, ones_d} = load_val_i;
        end else if (inc_i) begin
            if (ones_q == 4'd9) begin
                if (tens_q != 4'd9) begin
                    tens_d = tens_q + 4'd1;
                    ones_d = 4'd0;
                end
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end else if (dec_i) begin
            if (ones_q == 4'd0) begin
                if (tens_q != 4'd0) begin
                    tens_d = tens_q - 4'd1;
                    ones_d = 4'd9;
                end
            end else begin
                ones_d = ones_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            {tens_q, ones_q} <= RST_VAL;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign value_o = {tens_q, ones_q};

endmodule

// File: rtl/game_sequencer.sv
// Game controller: IDLE -> COUNTDOWN -> PLAY -> GAMEOVER with built-in one-second prescaler.
// Optional build macro GAME_ABORT_EN: start during COUNTDOWN/PLAY aborts back to IDLE.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   IDLE      | waiting for start; score/timer hold last values
//   COUNTDOWN | pre-game countdown, one step per tick
//   PLAY      | hits score, timer counts down per tick
//   GAMEOVER  | final score/timer hold until start
module game_sequencer
    import game_pkg::*;
#(
    parameter int CLKS_PER_SEC   = 100_000_000,
    parameter int COUNTDOWN_SECS = 5,
    parameter int GAME_SECS      = 30
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         hit,
    output logic [2:0]   current_state,
    output logic [3:0]   countdown_timer,
    output logic [7:0]   game_timer_bcd,
    output logic [7:0]   score_bcd,
    output logic         game_over
);

    localparam int              PS_W     = (CLKS_PER_SEC > 2) ? $clog2(CLKS_PER_SEC) : 1;
    localparam logic [PS_W-1:0] PS_LAST  = PS_W'(CLKS_PER_SEC - 1);
    localparam logic [7:0]      GAME_BCD = to_bcd2(GAME_SECS);

    state_e          state_q, state_d;
    logic [PS_W-1:0] presc_q, presc_d;
    logic [3:0]      cd_q, cd_d;
    logic            go_q, go_d;
    logic            running, tick, abort;
    logic            score_load, score_inc, timer_load, timer_dec;

    assign running = (state_q == S_COUNTDOWN) || (state_q == S_PLAY);
    assign tick    = running && (presc_q == PS_LAST);

`ifdef GAME_ABORT_EN
    assign abort = running && start;
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cd_d       = cd_q;
        go_d       = 1'b0;
        score_load = 1'b0;
        score_inc  = 1'b0;
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        if (abort) begin
            state_d    = S_IDLE;
            cd_d       = 4'd0;
            score_load = 1'b1;
            timer_load = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d    = S_COUNTDOWN;
                        cd_d       = 4'(COUNTDOWN_SECS);
                        score_load = 1'b1;
                        timer_load = 1'b1;
                    end
                end
                S_COUNTDOWN: begin
                    if (tick) begin
                        if (cd_q > 4'd1) begin
                            cd_d = cd_q - 4'd1;
                        end else begin
                            state_d = S_PLAY;
                            cd_d    = 4'd0;
                        end
                    end
                end
                S_PLAY: begin
                    // A hit on the final tick still counts toward the final score.
                    score_inc = hit;
                    if (tick) begin
                        timer_dec = 1'b1;
                        if (game_timer_bcd == 8'h01) begin
                            state_d = S_GAMEOVER;
                            go_d    = 1'b1;
                        end
                    end
                end
                S_GAMEOVER: begin
                    if (start) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Cleared on every transition so the first tick lands a full second after entry.
    always_comb begin
        if ((state_d != state_q) || !running || tick) presc_d = '0;
        else                                          presc_d = presc_q + PS_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            cd_q    <= 4'd0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            cd_q    <= cd_d;
            go_q    <= go_d;
        end
    end

    bcd2_counter #(.RST_VAL(8'h00)) u_score (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .load_i     (score_load),
        .load_val_i (8'h00),
        .inc_i      (score_inc),
        .dec_i      (1'b0),
        .value_o    (score_bcd)
    );

    bcd2_counter #(.RST_VAL(GAME_BCD)) u_timer (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .load_i     (timer_load),
        .load_val_i (GAME_BCD),
        .inc_i      (1'b0),
        .dec_i      (timer_dec),
        .value_o    (game_timer_bcd)
    );

    assign current_state   = state_q;
    assign countdown_timer = cd_q;
    assign game_over       = go_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer (CLKS_PER_SEC=4, COUNTDOWN_SECS=3, GAME_SECS=5).
module tb_game_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       hit = 1'b0;
    logic [2:0] current_state;
    logic [3:0] countdown_timer;
    logic [7:0] game_timer_bcd;
    logic [7:0] score_bcd;
    logic       game_over;

    logic       c_load = 1'b0, c_inc = 1'b0, c_dec = 1'b0;
    logic [7:0] c_val = 8'h00;
    logic [7:0] c_out;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       s;
        logic       h;
        logic [2:0] st;
        logic [3:0] cd;
        logic [7:0] tm;
        logic [7:0] sc;
        logic       go;
    } vec_t;

    vec_t vq[$];

    always #5 clk = ~clk;

    game_sequencer #(
        .CLKS_PER_SEC   (4),
        .COUNTDOWN_SECS (3),
        .GAME_SECS      (5)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .hit             (hit),
        .current_state   (current_state),
        .countdown_timer (countdown_timer),
        .game_timer_bcd  (game_timer_bcd),
        .score_bcd       (score_bcd),
        .game_over       (game_over)
    );

    bcd2_counter #(.RST_VAL(8'h00)) u_cnt (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .load_i     (c_load),
        .load_val_i (c_val),
        .inc_i      (c_inc),
        .dec_i      (c_dec),
        .value_o    (c_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] st, input logic [3:0] cd,
                             input logic [7:0] tm, input logic [7:0] sc, input logic go);
        check({tag, " state"}, 32'(current_state), 32'(st));
        check({tag, " countdown"}, 32'(countdown_timer), 32'(cd));
        check({tag, " timer"}, 32'(game_timer_bcd), 32'(tm));
        check({tag, " score"}, 32'(score_bcd), 32'(sc));
        check({tag, " game_over"}, 32'(game_over), 32'(go));
    endtask

    // Drive inputs for one edge, then leave the outputs settled #1 after it.
    task automatic step(input logic s, input logic h);
        start = s;
        hit   = h;
        @(posedge clk);
        #1;
        start = 1'b0;
        hit   = 1'b0;
    endtask

    task automatic cstep(input logic ld, input logic [7:0] v, input logic inc, input logic dec);
        c_load = ld;
        c_val  = v;
        c_inc  = inc;
        c_dec  = dec;
        @(posedge clk);
        #1;
        c_load = 1'b0;
        c_inc  = 1'b0;
        c_dec  = 1'b0;
    endtask

    task automatic add(input logic s, input logic h, input logic [2:0] st, input logic [3:0] cd,
                       input logic [7:0] tm, input logic [7:0] sc, input logic go);
        vec_t v;
        v.s = s; v.h = h; v.st = st; v.cd = cd; v.tm = tm; v.sc = sc; v.go = go;
        vq.push_back(v);
    endtask

    initial begin
        // Full game: countdown 3-2-1, 12 hits across BCD carry, final hit on final tick.
        add(1, 0, 1, 3, 8'h05, 8'h00, 0);
        add(0, 1, 1, 3, 8'h05, 8'h00, 0);
        repeat (2) add(0, 0, 1, 3, 8'h05, 8'h00, 0);
        repeat (4) add(0, 0, 1, 2, 8'h05, 8'h00, 0);
        repeat (4) add(0, 0, 1, 1, 8'h05, 8'h00, 0);
        add(0, 0, 2, 0, 8'h05, 8'h00, 0);
        add(0, 1, 2, 0, 8'h05, 8'h01, 0);
        add(0, 1, 2, 0, 8'h05, 8'h02, 0);
        add(0, 1, 2, 0, 8'h05, 8'h03, 0);
        add(0, 1, 2, 0, 8'h04, 8'h04, 0);
        add(0, 1, 2, 0, 8'h04, 8'h05, 0);
        add(0, 1, 2, 0, 8'h04, 8'h06, 0);
        add(0, 1, 2, 0, 8'h04, 8'h07, 0);
        add(0, 1, 2, 0, 8'h03, 8'h08, 0);
        add(0, 1, 2, 0, 8'h03, 8'h09, 0);
        add(0, 1, 2, 0, 8'h03, 8'h10, 0);
        add(0, 1, 2, 0, 8'h03, 8'h11, 0);
        add(0, 1, 2, 0, 8'h02, 8'h12, 0);
        repeat (3) add(0, 0, 2, 0, 8'h02, 8'h12, 0);
        repeat (4) add(0, 0, 2, 0, 8'h01, 8'h12, 0);
        add(0, 1, 3, 0, 8'h00, 8'h13, 1);
        add(0, 1, 3, 0, 8'h00, 8'h13, 0);
        add(1, 0, 0, 0, 8'h00, 8'h13, 0);

        // Reset values, checked while reset is still held.
        repeat (2) @(posedge clk);
        #3;
        check_all("reset", 3'd0, 4'd0, 8'h05, 8'h00, 1'b0);
        check("reset cnt", 32'(c_out), 32'h00);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Standalone BCD counter: floor, carry, saturation, borrow.
        cstep(0, 8'h00, 0, 1);
        check("cnt dec floor", 32'(c_out), 32'h00);
        for (int i = 0; i < 99; i++) begin
            cstep(0, 8'h00, 1, 0);
            if (i == 9) check("cnt carry 10", 32'(c_out), 32'h10);
        end
        check("cnt 99", 32'(c_out), 32'h99);
        cstep(0, 8'h00, 1, 0);
        check("cnt sat 99", 32'(c_out), 32'h99);
        cstep(0, 8'h00, 0, 1);
        check("cnt dec 98", 32'(c_out), 32'h98);
        cstep(1, 8'h10, 0, 0);
        cstep(0, 8'h00, 0, 1);
        check("cnt borrow 09", 32'(c_out), 32'h09);

        // Idle for 20 cycles; hits in IDLE are discarded.
        for (int i = 0; i < 20; i++) begin
            step(1'b0, i[0]);
            check("idle state", 32'(current_state), 32'd0);
            check("idle score", 32'(score_bcd), 32'h00);
            check("idle timer", 32'(game_timer_bcd), 32'h05);
        end

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].s, vq[i].h);
            check_all($sformatf("vec%0d", i), vq[i].st, vq[i].cd, vq[i].tm, vq[i].sc, vq[i].go);
        end

        // New game reloads score/timer; then start pressed during PLAY.
        step(1'b1, 1'b0);
        check_all("restart", 3'd1, 4'd3, 8'h05, 8'h00, 1'b0);
        repeat (12) step(1'b0, 1'b0);
        check_all("play entry", 3'd2, 4'd0, 8'h05, 8'h00, 1'b0);
        step(1'b1, 1'b0);
`ifdef GAME_ABORT_EN
        check_all("abort", 3'd0, 4'd0, 8'h05, 8'h00, 1'b0);
`else
        check_all("start in play", 3'd2, 4'd0, 8'h05, 8'h00, 1'b0);
        for (int i = 0; i < 19; i++) begin
            step(1'b0, 1'b1);
            if (i < 18) check("play go low", 32'(game_over), 32'd0);
        end
        check_all("hit every cycle end", 3'd3, 4'd0, 8'h00, 8'h19, 1'b1);
        step(1'b0, 1'b0);
        check("go one cycle", 32'(game_over), 32'd0);
        step(1'b1, 1'b0);
        check("back to idle", 32'(current_state), 32'd0);
`endif

        // Asynchronous reset mid-PLAY, then a clean countdown.
        step(1'b1, 1'b0);
        repeat (12) step(1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1);
        check("pre-reset score", 32'(score_bcd), 32'h03);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async reset", 3'd0, 4'd0, 8'h05, 8'h00, 1'b0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("post reset idle", 3'd0, 4'd0, 8'h05, 8'h00, 1'b0);
        step(1'b1, 1'b0);
        check_all("clean countdown", 3'd1, 4'd3, 8'h05, 8'h00, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        check("cd still 3", 32'(countdown_timer), 32'd3);
        step(1'b0, 1'b0);
        check("cd 2 after 4", 32'(countdown_timer), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level game controller that owns the IDLE → COUNTDOWN → PLAY → GAMEOVER sequence and produces every value the 8-digit display mux consumes: state code, countdown value, BCD game timer and BCD score. It sits between the debounced button/hit inputs and the display formatting logic. It contains its own one-second prescaler, so the rest of the design needs no separate timebase.

## Interface
- CLKS_PER_SEC, 100_000_000: clock cycles per game second; must be ≥ 2.
- COUNTDOWN_SECS, 5: countdown start value; range 1–9.
- GAME_SECS, 30: play duration in seconds; range 1–99.
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse from the debounced start button.
- hit  in  1  single-cycle pulse, one per scoring event.
- current_state  out  3  game state code: IDLE=0, COUNTDOWN=1, PLAY=2, GAMEOVER=3.
- countdown_timer  out  4  binary countdown value.
- game_timer_bcd  out  8  BCD seconds remaining: [7:4] tens, [3:0] ones.
- score_bcd  out  8  BCD score: [7:4] tens, [3:0] ones.
- game_over  out  1  one-cycle pulse on entry to GAMEOVER.

## Operation
- Reset values: current_state=IDLE, countdown_timer=0, game_timer_bcd=BCD(GAME_SECS), score_bcd=8'h00, game_over=0, prescaler=0.
- Prescaler
  - Counts 0..CLKS_PER_SEC-1 only in COUNTDOWN and PLAY.
  - `tick` asserts for one cycle at terminal count.
  - Cleared on every state transition, so the first tick in a state comes exactly CLKS_PER_SEC cycles after entry.
- IDLE
  - `start` → COUNTDOWN.
  - On that transition: countdown_timer=COUNTDOWN_SECS, score_bcd=00, game_timer_bcd=BCD(GAME_SECS).
- COUNTDOWN
  - `tick` with countdown_timer>1 → decrement.
  - `tick` with countdown_timer==1 → PLAY, countdown_timer=0.
  - `start` and `hit` are ignored.
- PLAY
  - `hit` → score_bcd increments in BCD: 09→10, 99 saturates.
  - `tick` → game_timer_bcd decrements in BCD: 10→09.
  - `tick` with timer==01 → timer=00, GAMEOVER, game_over=1 for one cycle.
  - `start` is ignored.
- GAMEOVER
  - Score and timer (00) hold.
  - `start` → IDLE; the next `start` begins a new game.
- Simultaneous events
  - `hit` and the final `tick` in the same cycle: the hit is counted; the final score includes it.
  - `hit` outside PLAY is discarded.
- BCD invariant: no digit ever exceeds 9; both nibbles are always valid BCD.
- Reset asserted mid-game: all outputs return to reset values immediately (asynchronous), with no game_over pulse.

## Timing
- All outputs are registered. An event sampled at edge N is visible after edge N.
- COUNTDOWN lasts exactly COUNTDOWN_SECS×CLKS_PER_SEC cycles. PLAY lasts exactly GAME_SECS×CLKS_PER_SEC cycles.
- game_over is high in the first GAMEOVER cycle only.
- Latency from `start` to current_state change: 1 cycle. Latency from `hit` to score update: 1 cycle.

## Configuration
- GAME_ABORT_EN defined: `start` in COUNTDOWN or PLAY aborts to IDLE.
  - Score and timers are reloaded as at reset.
  - The prescaler is cleared.
  - No game_over pulse.
- GAME_ABORT_EN undefined: `start` is ignored in COUNTDOWN and PLAY, as specified above.

## Structure
- Shared package game_pkg holds the state width, the state localparams (IDLE/COUNTDOWN/PLAY/GAMEOVER = 0..3) and the BCD digit width. The display mux uses the same package, so both blocks share one state encoding.
- One sub-module, bcd2_counter: a two-digit BCD counter with load, inc (saturating at 99) and dec (stopping at 00). It is instantiated twice, once for the score and once for the game timer.
- Prescaler and FSM live in game_sequencer itself.

## Test plan
Bench parameters: CLKS_PER_SEC=4, COUNTDOWN_SECS=3, GAME_SECS=5.
- Reset then idle 20 cycles → current_state=0, game_timer_bcd=8'h05, score_bcd=8'h00, no state change.
- `start` → next cycle current_state=1, countdown_timer=3. After 4, 8 and 12 cycles → 2, 1, then PLAY with game_timer_bcd=05.
- 12 `hit` pulses in PLAY → score_bcd=8'h12. Preload via a 99-hit run, then one more hit → stays 8'h99.
- `hit` coincident with the final `tick` → GAMEOVER, game_over high exactly one cycle, score includes that hit, timer=8'h00.
- `start` in PLAY → no effect without GAME_ABORT_EN. With GAME_ABORT_EN → IDLE next cycle, score_bcd=00.
- rst_n low mid-PLAY (asynchronous, between edges) → outputs reset immediately. After release, `start` begins a clean countdown from 3.
